// File: rtl/riscv_soft_ex_wb_buffer_if.sv
// Execute-to-writeback link: ALU result capture, writeback handshake, flush
// and the two forwarding taps.
interface riscv_soft_ex_wb_buffer_if #(
  parameter int XPR_LEN    = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [XPR_LEN-1:0]    in_result;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_wen;
  logic                  flush;

  logic                  out_valid;
  logic                  out_ready;
  logic [XPR_LEN-1:0]    out_result;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_wen;

  logic                  byp0_valid;
  logic [REG_ADDR_W-1:0] byp0_rd;
  logic [XPR_LEN-1:0]    byp0_result;
  logic                  byp1_valid;
  logic [REG_ADDR_W-1:0] byp1_rd;
  logic [XPR_LEN-1:0]    byp1_result;

  modport master (
    output in_valid, in_result, in_rd, in_wen, flush, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wen,
           byp0_valid, byp0_rd, byp0_result, byp1_valid, byp1_rd, byp1_result
  );

  modport slave (
    input  in_valid, in_result, in_rd, in_wen, flush, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wen,
           byp0_valid, byp0_rd, byp0_result, byp1_valid, byp1_rd, byp1_result
  );
endinterface

// File: rtl/riscv_soft_ex_wb_buffer.sv
// Two-entry skid buffer between the integer ALU and writeback; both held
// entries are exported as forwarding sources.
//
// state | meaning
// EMPTY | no entry held
// ONE   | head valid, skid empty
// FULL  | head and skid valid; in_ready low
module riscv_soft_ex_wb_buffer #(
  parameter int XPR_LEN    = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic                      clk,
  input logic                      reset,
  riscv_soft_ex_wb_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [XPR_LEN-1:0]    head_result, skid_result;
  logic [REG_ADDR_W-1:0] head_rd, skid_rd;
  logic                  head_wen, skid_wen;
  logic                  head_valid, skid_valid;

  logic acc, deq, in_wen_eff;
  logic load_head_in, load_head_skid, load_skid;

  assign head_valid = (state == ONE) || (state == FULL);
  assign skid_valid = (state == FULL);

  // in_ready comes straight from the state register, so it is registered
  assign bus.in_ready = !skid_valid;
  assign acc          = bus.in_valid && bus.in_ready;
  assign deq          = head_valid && bus.out_ready;

  // x0 is never written back nor forwarded
  assign in_wen_eff = bus.in_wen && (bus.in_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nxt    = ONE;
          load_head_in = 1'b1;
        end
      end
      ONE: begin
        if (acc && !deq) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (acc && deq) begin
          load_head_in = 1'b1;
        end else if (deq) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (deq) begin
          state_nxt      = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Data loads may still happen on a flush; only the valid state matters
    if (bus.flush) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_result <= '0;
      head_rd     <= '0;
      head_wen    <= 1'b0;
    end else if (load_head_in) begin
      head_result <= bus.in_result;
      head_rd     <= bus.in_rd;
      head_wen    <= in_wen_eff;
    end else if (load_head_skid) begin
      head_result <= skid_result;
      head_rd     <= skid_rd;
      head_wen    <= skid_wen;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_result <= '0;
      skid_rd     <= '0;
      skid_wen    <= 1'b0;
    end else if (load_skid) begin
      skid_result <= bus.in_result;
      skid_rd     <= bus.in_rd;
      skid_wen    <= in_wen_eff;
    end
  end

  assign bus.out_valid  = head_valid;
  assign bus.out_result = head_result;
  assign bus.out_rd     = head_rd;
  assign bus.out_wen    = head_wen;

  assign bus.byp0_valid  = head_valid && head_wen;
  assign bus.byp0_rd     = head_rd;
  assign bus.byp0_result = head_result;

  assign bus.byp1_valid  = skid_valid && skid_wen;
  assign bus.byp1_rd     = skid_rd;
  assign bus.byp1_result = skid_result;

endmodule

// File: tb/tb_riscv_soft_ex_wb_buffer.sv
// Bench for the EX/WB skid buffer: directed vector table, hand sequences for
// async reset and streaming, then random traffic against a queue model.
module tb_riscv_soft_ex_wb_buffer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  riscv_soft_ex_wb_buffer_if #(.XPR_LEN(32), .REG_ADDR_W(5)) bus ();

  riscv_soft_ex_wb_buffer #(.XPR_LEN(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic        e_b0v;
    logic        e_b1v;
    logic [31:0] e_b1res;
    logic [4:0]  e_b1rd;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  vec_t vecs[16];
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] res, input logic [4:0] rd,
                       input logic wen, input logic fl, input logic ordy);
    bus.in_valid  = iv;
    bus.in_result = res;
    bus.in_rd     = rd;
    bus.in_wen    = wen;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  // Reference: an ordered list of at most two entries
  task automatic model_edge();
    bit   acc, deq;
    ent_t e;
    acc = bus.in_valid && (q.size() < 2);
    deq = (q.size() > 0) && bus.out_ready;
    e.res = bus.in_result;
    e.rd  = bus.in_rd;
    e.wen = bus.in_wen && (bus.in_rd != 5'd0);
    if (deq) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (bus.flush) q.delete();
  endtask

  task automatic model_check();
    chk("m_in_ready", {31'b0, bus.in_ready}, {31'b0, q.size() < 2});
    chk("m_out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("m_out_result", bus.out_result, q[0].res);
      chk("m_out_rd", {27'b0, bus.out_rd}, {27'b0, q[0].rd});
      chk("m_out_wen", {31'b0, bus.out_wen}, {31'b0, q[0].wen});
      chk("m_byp0_valid", {31'b0, bus.byp0_valid}, {31'b0, q[0].wen});
      chk("m_byp0_rd", {27'b0, bus.byp0_rd}, {27'b0, q[0].rd});
      chk("m_byp0_result", bus.byp0_result, q[0].res);
    end else begin
      chk("m_byp0_valid", {31'b0, bus.byp0_valid}, 32'd0);
    end
    if (q.size() == 2) begin
      chk("m_byp1_valid", {31'b0, bus.byp1_valid}, {31'b0, q[1].wen});
      chk("m_byp1_rd", {27'b0, bus.byp1_rd}, {27'b0, q[1].rd});
      chk("m_byp1_result", bus.byp1_result, q[1].res);
    end else begin
      chk("m_byp1_valid", {31'b0, bus.byp1_valid}, 32'd0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(0, 32'h0, 5'd0, 0, 0, 0);
    reset = 1'b1;

    //         iv res          rd     wen fl or | ir ov res          rd     wen b0v b1v b1res     b1rd
    vecs[0]  = '{1, 32'h11,   5'd1,  1, 0, 1,  1, 1, 32'h11,   5'd1,  1, 1, 0, 32'h0, 5'd0};
    vecs[1]  = '{1, 32'h22,   5'd2,  1, 0, 1,  1, 1, 32'h22,   5'd2,  1, 1, 0, 32'h0, 5'd0};
    vecs[2]  = '{1, 32'h33,   5'd3,  1, 0, 1,  1, 1, 32'h33,   5'd3,  1, 1, 0, 32'h0, 5'd0};
    vecs[3]  = '{0, 32'h0,    5'd0,  0, 0, 1,  1, 0, 32'h0,    5'd0,  0, 0, 0, 32'h0, 5'd0};
    vecs[4]  = '{1, 32'hA,    5'd4,  1, 0, 0,  1, 1, 32'hA,    5'd4,  1, 1, 0, 32'h0, 5'd0};
    vecs[5]  = '{1, 32'hB,    5'd5,  1, 0, 0,  0, 1, 32'hA,    5'd4,  1, 1, 1, 32'hB, 5'd5};
    vecs[6]  = '{1, 32'hC,    5'd7,  1, 0, 0,  0, 1, 32'hA,    5'd4,  1, 1, 1, 32'hB, 5'd5};
    vecs[7]  = '{0, 32'h0,    5'd0,  0, 0, 1,  1, 1, 32'hB,    5'd5,  1, 1, 0, 32'h0, 5'd0};
    vecs[8]  = '{0, 32'h0,    5'd0,  0, 0, 1,  1, 0, 32'h0,    5'd0,  0, 0, 0, 32'h0, 5'd0};
    vecs[9]  = '{1, 32'hDEAD, 5'd0,  1, 0, 0,  1, 1, 32'hDEAD, 5'd0,  0, 0, 0, 32'h0, 5'd0};
    vecs[10] = '{1, 32'h44,   5'd8,  0, 0, 0,  0, 1, 32'hDEAD, 5'd0,  0, 0, 0, 32'h0, 5'd0};
    vecs[11] = '{1, 32'h77,   5'd9,  1, 1, 0,  1, 0, 32'h0,    5'd0,  0, 0, 0, 32'h0, 5'd0};
    vecs[12] = '{0, 32'h0,    5'd0,  0, 0, 1,  1, 0, 32'h0,    5'd0,  0, 0, 0, 32'h0, 5'd0};
    vecs[13] = '{1, 32'h55,   5'd10, 1, 0, 0,  1, 1, 32'h55,   5'd10, 1, 1, 0, 32'h0, 5'd0};
    vecs[14] = '{1, 32'h66,   5'd11, 1, 1, 1,  1, 0, 32'h0,    5'd0,  0, 0, 0, 32'h0, 5'd0};
    vecs[15] = '{0, 32'h0,    5'd0,  0, 0, 1,  1, 0, 32'h0,    5'd0,  0, 0, 0, 32'h0, 5'd0};

    #2;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_byp0_valid", {31'b0, bus.byp0_valid}, 32'd0);
    chk("rst_byp1_valid", {31'b0, bus.byp1_valid}, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].res, vecs[i].rd, vecs[i].wen, vecs[i].fl, vecs[i].ordy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, vecs[i].e_ir});
      chk($sformatf("v%0d_out_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].e_ov});
      chk($sformatf("v%0d_byp0_valid", i), {31'b0, bus.byp0_valid}, {31'b0, vecs[i].e_b0v});
      chk($sformatf("v%0d_byp1_valid", i), {31'b0, bus.byp1_valid}, {31'b0, vecs[i].e_b1v});
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_out_result", i), bus.out_result, vecs[i].e_res);
        chk($sformatf("v%0d_out_rd", i), {27'b0, bus.out_rd}, {27'b0, vecs[i].e_rd});
        chk($sformatf("v%0d_out_wen", i), {31'b0, bus.out_wen}, {31'b0, vecs[i].e_wen});
      end
      if (vecs[i].e_b0v) begin
        chk($sformatf("v%0d_byp0_rd", i), {27'b0, bus.byp0_rd}, {27'b0, vecs[i].e_rd});
        chk($sformatf("v%0d_byp0_result", i), bus.byp0_result, vecs[i].e_res);
      end
      if (vecs[i].e_b1v) begin
        chk($sformatf("v%0d_byp1_rd", i), {27'b0, bus.byp1_rd}, {27'b0, vecs[i].e_b1rd});
        chk($sformatf("v%0d_byp1_result", i), bus.byp1_result, vecs[i].e_b1res);
      end
    end

    // Async reset mid-cycle while FULL, no clock edge in between
    drive(1, 32'h81, 5'd12, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 32'h82, 5'd13, 1, 0, 0);
    @(posedge clk); #1;
    chk("ar_full_byp1_valid", {31'b0, bus.byp1_valid}, 32'd1);
    drive(0, 32'h0, 5'd0, 0, 0, 0);
    #1 reset = 1'b1;
    #1;
    chk("ar_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("ar_byp0_valid", {31'b0, bus.byp0_valid}, 32'd0);
    chk("ar_byp1_valid", {31'b0, bus.byp1_valid}, 32'd0);
    chk("ar_in_ready", {31'b0, bus.in_ready}, 32'd1);
    #1 reset = 1'b0;
    drive(1, 32'h5, 5'd6, 1, 0, 0);
    @(posedge clk); #1;
    chk("ar_new_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("ar_new_out_result", bus.out_result, 32'h5);
    chk("ar_new_out_rd", {27'b0, bus.out_rd}, 32'd6);

    // Streaming with acc and deq together never fills the skid slot
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h90 + k, 5'(14 + k), 1, 0, 1);
      @(posedge clk); #1;
      chk($sformatf("st%0d_in_ready", k), {31'b0, bus.in_ready}, 32'd1);
      chk($sformatf("st%0d_out_result", k), bus.out_result, 32'h90 + k);
      chk($sformatf("st%0d_byp1_valid", k), {31'b0, bus.byp1_valid}, 32'd0);
    end

    // Random traffic against the queue model, starting from a clean reset
    drive(0, 32'h0, 5'd0, 0, 0, 0);
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    q.delete();
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0);
      model_edge();
      @(posedge clk); #1;
      model_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_soft_ex_wb_buffer.md
Name: riscv_soft_ex_wb_buffer

Overview:
- Downstream of the integer ALU. Captures each ALU result with its destination register index and write-enable, then hands it to writeback over a valid/ready handshake.
- A two-entry skid buffer decouples writeback back-pressure from the combinational execute stage.
- Exposes both held entries as bypass sources for operand forwarding.
- Supports a pipeline flush on branch mispredict or trap.

Parameters:
- XPR_LEN, 32, data path width; matches the ALU.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  buffer can accept this cycle.
- in_result  in  XPR_LEN  ALU result.
- in_rd  in  REG_ADDR_W  destination register index.
- in_wen  in  1  instruction writes rd.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback accepts head.
- out_result  out  XPR_LEN  head result.
- out_rd  out  REG_ADDR_W  head rd.
- out_wen  out  1  head write-enable.
- byp0_valid  out  1  head entry is forwardable (valid and wen).
- byp0_rd  out  REG_ADDR_W  head rd.
- byp0_result  out  XPR_LEN  head result.
- byp1_valid  out  1  skid entry is forwardable (valid and wen).
- byp1_rd  out  REG_ADDR_W  skid rd.
- byp1_result  out  XPR_LEN  skid result; younger than head, so the consumer gives it priority.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - head and skid valid bits = 0; all stored fields = 0.
  - in_ready = 1; out_valid = 0; byp0_valid = 0; byp1_valid = 0.
- Storage:
  - head register drives out_* and byp0_*.
  - skid register drives byp1_*.
- Occupancy states: EMPTY (no entries), ONE (head only), FULL (head and skid). A skid entry never exists without a valid head.
- Handshakes:
  - in_ready is registered: in_ready = !skid_valid.
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
- Capture: if in_rd == 0, the stored wen is forced to 0 (x0 is never written and never forwarded).
- Transitions (no flush):
  - EMPTY, acc -> ONE; head := input.
  - ONE, acc & !deq -> FULL; skid := input.
  - ONE, acc & deq -> ONE; head := input.
  - ONE, !acc & deq -> EMPTY.
  - ONE, no event -> ONE; hold.
  - FULL, deq -> ONE; head := skid. No acc is possible because in_ready = 0.
  - FULL, !deq -> FULL; hold.
- Ordering: strict FIFO order is always preserved.
- Latency: an entry accepted at edge N is on out_* from edge N onward (registered output, visible the cycle after the handshake).
- Throughput: one entry per cycle when out_ready is held high.
- Flush: synchronous. At the edge where flush = 1:
  - all valid bits clear and the state becomes EMPTY;
  - any acc in that cycle is dropped;
  - a deq in that same cycle is still counted as delivered;
  - data fields need not be cleared.
- Output stability: while out_valid = 1 and out_ready = 0, out_* remain stable until deq or flush.
- Bypass outputs: combinational from stored state only, never from in_*.
- Reset mid-operation: all entries are lost and the block returns to the reset state immediately.

Test Plan:
- Stream, out_ready = 1: feed results 0x11, 0x22, 0x33 (rd 1, 2, 3) on consecutive cycles -> out_valid high for 3 consecutive cycles, each starting one cycle after its input, values in order; in_ready stays 1.
- Back-pressure: out_ready = 0; feed 0xA (rd 4) then 0xB (rd 5) -> in_ready = 0 after the second edge; byp0 = {4, 0xA}, byp1 = {5, 0xB}. Then raise out_ready -> out_* shows 0xA then 0xB; in_ready returns to 1 the cycle after the first deq.
- x0 suppression: feed in_rd = 0, in_wen = 1, result 0xDEAD -> out_valid = 1, out_wen = 0, byp0_valid = 0.
- Flush while FULL with in_valid = 1 -> next cycle out_valid = 0, byp*_valid = 0, in_ready = 1; the flushed input never appears on out_*.
- Asynchronous reset asserted mid-cycle while FULL -> out_valid, byp0_valid, byp1_valid drop without waiting for a clock edge; in_ready = 1; after release a new input 0x5 (rd 6) appears normally.
- Simultaneous acc and deq in ONE, with out_ready = 1 and in_valid held 4 cycles -> occupancy never reaches FULL and in_ready never drops.
